// File: rtl/ex_pkg.sv
// Shared constants for the execute stage.
// Holds ALU op codes, forward selects, mul/div op codes and FSM states.
package ex_pkg;

   localparam logic [3:0] ALU_AND    = 4'h0;
   localparam logic [3:0] ALU_OR     = 4'h1;
   localparam logic [3:0] ALU_ADD    = 4'h2;
   localparam logic [3:0] ALU_SLL    = 4'h3;
   localparam logic [3:0] ALU_SRL    = 4'h4;
   localparam logic [3:0] ALU_SRA    = 4'h5;
   localparam logic [3:0] ALU_SUB    = 4'h6;
   localparam logic [3:0] ALU_SLT    = 4'h7;
   localparam logic [3:0] ALU_NOR    = 4'h8;
   localparam logic [3:0] ALU_SLTU   = 4'h9;
   localparam logic [3:0] ALU_MULLO  = 4'hA;
   localparam logic [3:0] ALU_MULHIU = 4'hB;
   localparam logic [3:0] ALU_DIVU   = 4'hC;
   localparam logic [3:0] ALU_REMU   = 4'hD;

   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_WB = 2'b01;
   localparam logic [1:0] FWD_EX = 2'b10;

   // Low two bits of the mul/div ALU codes.
   localparam logic [1:0] MD_DIVU   = 2'b00;
   localparam logic [1:0] MD_REMU   = 2'b01;
   localparam logic [1:0] MD_MULLO  = 2'b10;
   localparam logic [1:0] MD_MULHIU = 2'b11;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   function automatic logic is_md_op(input logic [3:0] op);
      return op inside {ALU_MULLO, ALU_MULHIU, ALU_DIVU, ALU_REMU};
   endfunction

endpackage

// File: rtl/stage3_ex_md_md_iter.sv
// Iterative radix-2 multiply / restoring divide unit.
// One step per clock; result is presented combinationally on the last step.
module md_iter
   import ex_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rstb,
   input  logic          start_i,
   input  logic          abort_i,
   input  logic [1:0]    op_i,
   input  logic [DW-1:0] a_i,
   input  logic [DW-1:0] b_i,
   output logic          done_o,
   output logic [DW-1:0] result_o
);

   localparam int CW = $clog2(DW) + 1;

   logic          run_q;
   logic [CW-1:0] cnt_q;
   logic [1:0]    op_q;
   logic [DW-1:0] hi_q, lo_q, b_q;
   logic [DW-1:0] hi_d, lo_d;
   logic [DW:0]   sum, shl, diff;
   logic          is_mul, sel_hi;

   assign is_mul = op_q inside {MD_MULLO, MD_MULHIU};
   assign sel_hi = op_q inside {MD_MULHIU, MD_REMU};

   // One shift-add or restoring-subtract step on {hi,lo}.
   always_comb begin
      hi_d = hi_q;
      lo_d = lo_q;
      sum  = {1'b0, hi_q} + {1'b0, (lo_q[0] ? b_q : '0)};
      shl  = {hi_q, lo_q[DW-1]};
      diff = shl - {1'b0, b_q};
      if (is_mul) begin
         hi_d = sum[DW:1];
         lo_d = {sum[0], lo_q[DW-1:1]};
      end else if (diff[DW]) begin
         hi_d = shl[DW-1:0];
         lo_d = {lo_q[DW-2:0], 1'b0};
      end else begin
         hi_d = diff[DW-1:0];
         lo_d = {lo_q[DW-2:0], 1'b1};
      end
   end

   assign done_o   = run_q & (cnt_q == CW'(DW - 1));
   assign result_o = sel_hi ? hi_d : lo_d;

   // Operand capture on start, then one step per cycle until done.
   always_ff @(posedge clk) begin
      if (rstb || abort_i) begin
         run_q <= 1'b0;
         cnt_q <= '0;
         op_q  <= '0;
         hi_q  <= '0;
         lo_q  <= '0;
         b_q   <= '0;
      end else if (start_i) begin
         run_q <= 1'b1;
         cnt_q <= '0;
         op_q  <= op_i;
         hi_q  <= '0;
         lo_q  <= a_i;
         b_q   <= b_i;
      end else if (run_q) begin
         hi_q  <= hi_d;
         lo_q  <= lo_d;
         cnt_q <= cnt_q + 1'b1;
         if (done_o) run_q <= 1'b0;
      end
   end

endmodule

// File: rtl/stage3_ex_md.sv
// Execute stage: forwarding, ALU, branch adder, mul/div glue, EX/MEM regs.
// Mul/div ops stall the front end via in_ready until the unit finishes.
module stage3_ex_md
   import ex_pkg::*;
#(
   parameter int DW = 32,
   parameter int AW = 5
) (
   input  logic          clk,
   input  logic          rstb,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          if_flush,
   input  logic [DW-1:0] pc_plus4,
   input  logic [DW-1:0] regA_rd_data,
   input  logic [DW-1:0] regB_rd_data_in,
   input  logic [DW-1:0] imm_exted,
   input  logic [AW-1:0] regT_addr,
   input  logic [AW-1:0] regD_addr,
   input  logic [3:0]    alu_ctrl,
   input  logic          reg_dst,
   input  logic          alu_src,
   input  logic [1:0]    forwardA,
   input  logic [1:0]    forwardB,
   input  logic [DW-1:0] reg_wr_data_wb,
   output logic          out_valid,
   output logic [DW-1:0] alu_result,
   output logic          alu_zero,
   output logic          alu_not_zero,
   output logic          alu_greater,
   output logic          alu_ovf,
   output logic [DW-1:0] regB_rd_data_out,
   output logic [DW-1:0] pc_plus4_plusimm16,
   output logic [AW-1:0] reg_wr_addr
);

   localparam int SW = $clog2(DW);

   state_t        state_q, state_d;
   logic          accept, is_md, md_start, md_done, md_abort;
   logic [DW-1:0] md_res;
   logic [DW-1:0] op_a, fwd_b, op_b, alu_res, tgt, sum_w, dif_w;
   logic          ovf_c;
   logic [SW-1:0] shamt;
   logic [AW-1:0] dst;

   logic [AW-1:0] dst_q;
   logic [DW-1:0] stb_q, tgt_q;

   logic          vld_q, vld_d;
   logic [DW-1:0] res_q, res_d;
   logic          ovf_q, ovf_d;
   logic          zero_q, zero_d, nz_q, nz_d, gt_q, gt_d;
   logic [DW-1:0] ostb_q, ostb_d, otgt_q, otgt_d;
   logic [AW-1:0] addr_q, addr_d;

   assign is_md    = is_md_op(alu_ctrl);
   assign accept   = in_valid & in_ready & ~if_flush;
   assign md_start = accept & is_md;
   assign md_abort = if_flush & (state_q == ST_BUSY);
   assign shamt    = imm_exted[6 +: SW];
   assign dst      = reg_dst ? regD_addr : regT_addr;
   assign tgt      = pc_plus4 + (imm_exted << 2);

   // Operand forwarding; EX source is the registered result.
   always_comb begin
      unique case (forwardA)
         FWD_WB:  op_a = reg_wr_data_wb;
         FWD_EX:  op_a = res_q;
         default: op_a = regA_rd_data;
      endcase
      unique case (forwardB)
         FWD_WB:  fwd_b = reg_wr_data_wb;
         FWD_EX:  fwd_b = res_q;
         default: fwd_b = regB_rd_data_in;
      endcase
      op_b = alu_src ? imm_exted : fwd_b;
   end

   assign sum_w = op_a + op_b;
   assign dif_w = op_a - op_b;

   // Single-cycle ALU with signed overflow on ADD/SUB.
   always_comb begin
      alu_res = '0;
      ovf_c   = 1'b0;
      unique case (alu_ctrl)
         ALU_AND:  alu_res = op_a & op_b;
         ALU_OR:   alu_res = op_a | op_b;
         ALU_ADD: begin
            alu_res = sum_w;
            ovf_c   = (op_a[DW-1] == op_b[DW-1]) &
                      (sum_w[DW-1] != op_a[DW-1]);
         end
         ALU_SLL:  alu_res = op_b << shamt;
         ALU_SRL:  alu_res = op_b >> shamt;
         ALU_SRA:  alu_res = $unsigned($signed(op_b) >>> shamt);
         ALU_SUB: begin
            alu_res = dif_w;
            ovf_c   = (op_a[DW-1] != op_b[DW-1]) &
                      (dif_w[DW-1] != op_a[DW-1]);
         end
         ALU_SLT:
            alu_res = {{(DW-1){1'b0}}, $signed(op_a) < $signed(op_b)};
         ALU_NOR:  alu_res = ~(op_a | op_b);
         ALU_SLTU: alu_res = {{(DW-1){1'b0}}, op_a < op_b};
         default:  alu_res = '0;
      endcase
   end

   md_iter #(.DW(DW)) u_md (
      .clk      (clk),
      .rstb     (rstb),
      .start_i  (md_start),
      .abort_i  (md_abort),
      .op_i     (alu_ctrl[1:0]),
      .a_i      (op_a),
      .b_i      (op_b),
      .done_o   (md_done),
      .result_o (md_res)
   );

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rstb) state_q <= ST_IDLE;
      else      state_q <= state_d;
   end

   // FSM next state: flush or last step returns to IDLE.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (md_start) state_d = ST_BUSY;
         ST_BUSY: if (if_flush || md_done) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM output: accept only while idle.
   always_comb begin
      in_ready = (state_q == ST_IDLE);
   end

   // Hold destination and store data of the in-flight mul/div.
   always_ff @(posedge clk) begin
      if (rstb) begin
         dst_q <= '0;
         stb_q <= '0;
         tgt_q <= '0;
      end else if (md_start) begin
         dst_q <= dst;
         stb_q <= fwd_b;
         tgt_q <= tgt;
      end
   end

   // EX/MEM next value: ALU result, mul/div result, or bubble.
   always_comb begin
      vld_d  = 1'b0;
      res_d  = '0;
      ovf_d  = 1'b0;
      ostb_d = '0;
      otgt_d = '0;
      addr_d = '0;
      if (accept && !is_md) begin
         vld_d  = 1'b1;
         res_d  = alu_res;
         ovf_d  = ovf_c;
         ostb_d = fwd_b;
         otgt_d = tgt;
         addr_d = dst;
      end else if (state_q == ST_BUSY && md_done && !if_flush) begin
         vld_d  = 1'b1;
         res_d  = md_res;
         ostb_d = stb_q;
         otgt_d = tgt_q;
         addr_d = dst_q;
      end
      zero_d = vld_d & (res_d == '0);
      nz_d   = vld_d & (res_d != '0);
      gt_d   = vld_d & ~res_d[DW-1] & (res_d != '0);
   end

   // EX/MEM output registers.
   always_ff @(posedge clk) begin
      if (rstb) begin
         vld_q  <= 1'b0;
         res_q  <= '0;
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
         nz_q   <= 1'b0;
         gt_q   <= 1'b0;
         ostb_q <= '0;
         otgt_q <= '0;
         addr_q <= '0;
      end else begin
         vld_q  <= vld_d;
         res_q  <= res_d;
         ovf_q  <= ovf_d;
         zero_q <= zero_d;
         nz_q   <= nz_d;
         gt_q   <= gt_d;
         ostb_q <= ostb_d;
         otgt_q <= otgt_d;
         addr_q <= addr_d;
      end
   end

   assign out_valid          = vld_q;
   assign alu_result         = res_q;
   assign alu_ovf            = ovf_q;
   assign alu_zero           = zero_q;
   assign alu_not_zero       = nz_q;
   assign alu_greater        = gt_q;
   assign regB_rd_data_out   = ostb_q;
   assign pc_plus4_plusimm16 = otgt_q;
   assign reg_wr_addr        = addr_q;

endmodule

// File: tb/tb_stage3_ex_md.sv
// Bench for stage3_ex_md: directed plan steps plus randomized ops
// checked against an arithmetic reference model.
module tb_stage3_ex_md;
   import ex_pkg::*;

   logic        clk = 1'b0;
   logic        rstb;
   logic        in_valid, in_ready, if_flush;
   logic [31:0] pc_plus4, regA_rd_data, regB_rd_data_in, imm_exted;
   logic [4:0]  regT_addr, regD_addr;
   logic [3:0]  alu_ctrl;
   logic        reg_dst, alu_src;
   logic [1:0]  forwardA, forwardB;
   logic [31:0] reg_wr_data_wb;
   logic        out_valid, alu_zero, alu_not_zero, alu_greater, alu_ovf;
   logic [31:0] alu_result, regB_rd_data_out, pc_plus4_plusimm16;
   logic [4:0]  reg_wr_addr;

   int          n_chk  = 0;
   int          n_fail = 0;
   logic [31:0] m_res  = '0;

   always #5 clk = ~clk;

   stage3_ex_md #(.DW(32), .AW(5)) dut (
      .clk(clk), .rstb(rstb),
      .in_valid(in_valid), .in_ready(in_ready), .if_flush(if_flush),
      .pc_plus4(pc_plus4), .regA_rd_data(regA_rd_data),
      .regB_rd_data_in(regB_rd_data_in), .imm_exted(imm_exted),
      .regT_addr(regT_addr), .regD_addr(regD_addr),
      .alu_ctrl(alu_ctrl), .reg_dst(reg_dst), .alu_src(alu_src),
      .forwardA(forwardA), .forwardB(forwardB),
      .reg_wr_data_wb(reg_wr_data_wb),
      .out_valid(out_valid), .alu_result(alu_result),
      .alu_zero(alu_zero), .alu_not_zero(alu_not_zero),
      .alu_greater(alu_greater), .alu_ovf(alu_ovf),
      .regB_rd_data_out(regB_rd_data_out),
      .pc_plus4_plusimm16(pc_plus4_plusimm16),
      .reg_wr_addr(reg_wr_addr)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Returns {ovf, result} from plain arithmetic.
   function automatic logic [32:0] model_alu(input logic [3:0] op,
      input logic [31:0] a, input logic [31:0] b, input int sh);
      longint      sa = $signed(a);
      longint      sb = $signed(b);
      longint      t;
      logic [31:0] r = '0;
      logic        v = 1'b0;
      case (op)
         ALU_AND:  r = a & b;
         ALU_OR:   r = a | b;
         ALU_ADD: begin
            t = sa + sb; r = 32'(t);
            v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
         end
         ALU_SLL:  r = b << sh;
         ALU_SRL:  r = b >> sh;
         ALU_SRA:  r = 32'(sb >>> sh);
         ALU_SUB: begin
            t = sa - sb; r = 32'(t);
            v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
         end
         ALU_SLT:  r = (sa < sb) ? 32'd1 : 32'd0;
         ALU_NOR:  r = ~(a | b);
         ALU_SLTU: r = (a < b) ? 32'd1 : 32'd0;
         default:  r = '0;
      endcase
      return {v, r};
   endfunction

   function automatic logic [31:0] model_md(input logic [3:0] op,
      input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p = {32'd0, a} * {32'd0, b};
      case (op)
         ALU_MULLO:  return p[31:0];
         ALU_MULHIU: return p[63:32];
         ALU_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
         default:    return (b == 0) ? a : a % b;
      endcase
   endfunction

   task automatic chk_bub(input string tag);
      chk({tag, ".valid"}, 32'(out_valid), 0);
      chk({tag, ".res"}, alu_result, 0);
      chk({tag, ".addr"}, 32'(reg_wr_addr), 0);
      chk({tag, ".flags"},
          {28'd0, alu_zero, alu_not_zero, alu_greater, alu_ovf}, 0);
   endtask

   task automatic chk_rst(input string tag);
      chk_bub(tag);
      chk({tag, ".stb"}, regB_rd_data_out, 0);
      chk({tag, ".tgt"}, pc_plus4_plusimm16, 0);
      chk({tag, ".rdy"}, 32'(in_ready), 1);
   endtask

   task automatic chk_res(input string tag, input logic [31:0] er,
                          input logic eovf, input logic [4:0] ea);
      logic ez  = (er == 0);
      logic egt = ($signed(er) > 0);
      chk({tag, ".valid"}, 32'(out_valid), 1);
      chk({tag, ".res"}, alu_result, er);
      chk({tag, ".addr"}, 32'(reg_wr_addr), 32'(ea));
      chk({tag, ".flags"},
          {28'd0, alu_zero, alu_not_zero, alu_greater, alu_ovf},
          {28'd0, ez, !ez, egt, eovf});
   endtask

   task automatic do_single(input string tag, input logic [3:0] op,
      input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
      input logic src, input logic [1:0] fa, input logic [1:0] fb,
      input logic [31:0] wbd, input logic [31:0] pc, input logic fl);
      logic [31:0] oa, obf, ob, etgt;
      logic [32:0] m;
      logic [4:0]  rt = 5'($urandom);
      logic [4:0]  rd = 5'($urandom);
      logic        rdst = 1'($urandom);
      @(negedge clk);
      in_valid = 1'b1; if_flush = fl; alu_ctrl = op;
      regA_rd_data = a; regB_rd_data_in = b; imm_exted = im;
      alu_src = src; forwardA = fa; forwardB = fb;
      reg_wr_data_wb = wbd; pc_plus4 = pc;
      regT_addr = rt; regD_addr = rd; reg_dst = rdst;
      oa   = (fa == 2'b01) ? wbd : (fa == 2'b10) ? m_res : a;
      obf  = (fb == 2'b01) ? wbd : (fb == 2'b10) ? m_res : b;
      ob   = src ? im : obf;
      m    = model_alu(op, oa, ob, int'(im[10:6]));
      etgt = pc + im * 4;
      @(posedge clk); #1;
      chk({tag, ".rdy"}, 32'(in_ready), 1);
      if (fl) begin
         chk_bub(tag);
         m_res = '0;
      end else begin
         chk_res(tag, m[31:0], m[32], rdst ? rd : rt);
         chk({tag, ".stb"}, regB_rd_data_out, obf);
         chk({tag, ".tgt"}, pc_plus4_plusimm16, etgt);
         m_res = m[31:0];
      end
   endtask

   // kind: 0 none, 1 flush, 2 reset; applied before edge N+at.
   task automatic do_md(input string tag, input logic [3:0] op,
      input logic [31:0] a, input logic [31:0] b, input int kind,
      input int at);
      logic [31:0] exp = model_md(op, a, b);
      logic [4:0]  rd = 5'($urandom);
      bit          gone = 1'b0;
      @(negedge clk);
      in_valid = 1'b1; if_flush = 1'b0; alu_ctrl = op;
      regA_rd_data = a; regB_rd_data_in = b; alu_src = 1'b0;
      forwardA = FWD_RF; forwardB = FWD_RF; reg_dst = 1'b1;
      regD_addr = rd; regT_addr = 5'($urandom);
      imm_exted = $urandom; pc_plus4 = $urandom;
      @(posedge clk); #1;
      m_res = '0;
      chk({tag, ".acc.rdy"}, 32'(in_ready), 0);
      chk_bub({tag, ".acc"});
      for (int k = 1; k <= 32; k++) begin
         @(negedge clk);
         if_flush = 1'b0; rstb = 1'b0;
         in_valid = gone ? 1'b0 : 1'($urandom);
         regA_rd_data = $urandom; regB_rd_data_in = $urandom;
         forwardA = 2'($urandom); forwardB = 2'($urandom);
         reg_wr_data_wb = $urandom; alu_ctrl = 4'($urandom);
         if (!gone && kind == 1 && k == at) if_flush = 1'b1;
         if (!gone && kind == 2 && k == at) rstb = 1'b1;
         @(posedge clk); #1;
         if (!gone && kind != 0 && k == at) begin
            gone = 1'b1;
            chk({tag, ".abort.rdy"}, 32'(in_ready), 1);
            if (kind == 2) chk_rst({tag, ".rst"});
            else chk_bub({tag, ".flush"});
            m_res = '0;
         end else if (gone) begin
            chk({tag, ".nopulse"}, 32'(out_valid), 0);
            m_res = '0;
         end else if (k < 32) begin
            if (k == 1 || k == 10 || k == 31) begin
               chk({tag, ".busy.rdy"}, 32'(in_ready), 0);
               chk({tag, ".busy.valid"}, 32'(out_valid), 0);
            end
            m_res = '0;
         end else begin
            chk_res(tag, exp, 1'b0, rd);
            chk({tag, ".done.rdy"}, 32'(in_ready), 1);
            m_res = exp;
         end
      end
      @(negedge clk);
      in_valid = 1'b0; if_flush = 1'b0; rstb = 1'b0;
      @(posedge clk); #1;
      chk_bub({tag, ".after"});
      m_res = '0;
   endtask

   initial begin
      rstb = 1'b1; in_valid = 1'b0; if_flush = 1'b0;
      pc_plus4 = '0; regA_rd_data = '0; regB_rd_data_in = '0;
      imm_exted = '0; regT_addr = '0; regD_addr = '0;
      alu_ctrl = '0; reg_dst = 1'b0; alu_src = 1'b0;
      forwardA = '0; forwardB = '0; reg_wr_data_wb = '0;
      repeat (2) @(posedge clk);
      #1 chk_rst("reset");
      @(negedge clk) rstb = 1'b0;

      do_single("add", ALU_ADD, 5, 7, 0, 0, 0, 0, 0, 0, 0);
      do_single("fwdA", ALU_ADD, 0, 0, 4, 1, FWD_EX, 0, 0, 0, 0);
      do_single("fwdB", ALU_OR, 0, 0, 0, 0, 0, FWD_WB, 32'hAA, 0, 0);
      do_single("ovf", ALU_ADD, 32'h7FFF_FFFF, 1, 0, 0, 0, 0, 0, 0, 0);
      do_single("sub0", ALU_SUB, 3, 3, 0, 0, 0, 0, 0, 0, 0);
      do_single("subovf", ALU_SUB, 32'h8000_0000, 1, 0, 0, 0, 0, 0, 0, 0);
      do_single("brtgt", ALU_AND, 1, 1, 32'hFFFF_FFFF, 0, 0, 0, 0,
                32'h100, 0);
      do_single("sra", ALU_SRA, 0, 32'h8000_00F0, 32'h0000_0100,
                0, 0, 0, 0, 0, 0);
      do_single("undef", 4'hE, 9, 9, 0, 0, 0, 0, 0, 0, 0);
      do_single("flushin", ALU_ADD, 5, 7, 0, 0, 0, 0, 0, 0, 1);
      do_single("fwdbub", ALU_OR, 0, 0, 0, 0, FWD_EX, 0, 0, 0, 0);

      do_md("mullo", ALU_MULLO, 32'hFFFF, 32'h10001, 0, 0);
      do_md("mulhiu", ALU_MULHIU, 32'hFFFF_FFFF, 2, 0, 0);
      do_md("divu", ALU_DIVU, 100, 7, 0, 0);
      do_md("remu", ALU_REMU, 100, 7, 0, 0);
      do_md("div0", ALU_DIVU, 9, 0, 0, 0);
      do_md("rem0", ALU_REMU, 9, 0, 0, 0);
      do_md("divflush", ALU_DIVU, 1000, 3, 1, 10);
      do_md("mulrst", ALU_MULLO, 32'h1234, 32'h5678, 2, 5);
      do_md("flushlast", ALU_MULLO, 3, 5, 1, 32);
      do_single("postabort", ALU_ADD, 1, 2, 0, 0, 0, 0, 0, 0, 0);

      for (int i = 0; i < 150; i++) begin
         logic [3:0]  op = (i % 16 == 15) ? 4'hF : 4'($urandom_range(0, 9));
         logic [31:0] a = (i % 7 == 0) ? 32'h7FFF_FFFF : $urandom;
         logic [31:0] b = (i % 5 == 0) ? 32'h8000_0000 : $urandom;
         do_single("rnd", op, a, b, $urandom, 1'($urandom),
                   2'($urandom), 2'($urandom), $urandom, $urandom, 1'b0);
      end
      for (int i = 0; i < 8; i++) begin
         logic [31:0] b = (i == 3) ? 32'd0 :
                          (i % 2 == 0) ? $urandom_range(1, 300) : $urandom;
         do_md("rndmd", 4'($urandom_range(10, 13)), $urandom, b, 0, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/stage3_ex_md.md
# stage3_ex_md

Parametrised execute stage for the pipelined MIPS-style core, sitting between the ID/EX and EX/MEM boundaries. It generalises the execute stage in three ways:
- Data width and register-address width are parameters.
- The ALU op set is wider and adds signed-overflow reporting.
- An iterative multiply/divide unit stalls the front end through a ready handshake.

Forwarding muxes, branch-target adder, destination select and the registered EX/MEM outputs are all part of this block.

## Interface
- `DW`, 32: datapath width; must be ≥ 8 and a power of two.
- `AW`, 5: register-address width.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rstb` in 1: synchronous, active-high reset.
- `in_valid` in 1: ID/EX holds a real instruction.
- `in_ready` out 1: stage accepts this cycle. It equals state==IDLE and is combinational from state only.
- `if_flush` in 1: kill the current input and any in-flight mul/div.
- `pc_plus4` in DW: PC+4 of the instruction.
- `regA_rd_data`, `regB_rd_data_in` in DW: register file operands.
- `imm_exted` in DW: sign/zero-extended immediate. The shift amount is `imm_exted[6 +: log2(DW)]`.
- `regT_addr`, `regD_addr` in AW: rt and rd.
- `alu_ctrl` in 4: op code from the shared package.
- `reg_dst` in 1: 1 selects rd, 0 selects rt.
- `alu_src` in 1: 1 selects the immediate as operand B.
- `forwardA`, `forwardB` in 2: operand source. 00 = register file, 01 = `reg_wr_data_wb`, 10 = this stage's `alu_result`, 11 = register file.
- `reg_wr_data_wb` in DW: WB-stage write data.
- `out_valid` out 1: EX/MEM holds a valid result.
- `alu_result` out DW: registered result.
- `alu_zero`, `alu_not_zero`, `alu_greater`, `alu_ovf` out 1: registered flags.
- `regB_rd_data_out` out DW: registered forwarded operand B (store data).
- `pc_plus4_plusimm16` out DW: registered branch target.
- `reg_wr_addr` out AW: registered destination; 0 on any bubble.

## Operation
- **Forwarding and operands**
  - Forwarding resolves A and B first.
  - Operand B is then the forwarded B, or `imm_exted` when `alu_src`=1.
- **Branch target:** `pc_plus4 + (imm_exted << 2)`, modulo 2^DW.
- **Single-cycle ops:**
  - AND, OR, ADD, SLL, SRL, SRA, SUB, SLT (signed), NOR, SLTU.
  - ADD and SUB wrap modulo 2^DW.
  - `alu_ovf`=1 only on signed overflow of ADD or SUB; it is 0 for every other op.
  - Undefined codes give result 0 with flags computed from that 0.
- **Multi-cycle ops:**
  - MULLO: low DW bits of the unsigned product.
  - MULHIU: high DW bits of the unsigned product.
  - DIVU, REMU: unsigned quotient and remainder.
  - Dividing by zero gives quotient all-ones and remainder equal to the dividend.
  - Operands are captured at acceptance; forwarding inputs are ignored while busy.
- **Flags, computed on the final result:**
  - `alu_zero` = result==0.
  - `alu_not_zero` = its inverse.
  - `alu_greater` = ~result[DW-1] & ~zero.
- **FSM:**
  - IDLE → BUSY on acceptance of a mul/div op. Acceptance means `in_valid` & `in_ready` & ~`if_flush`.
  - BUSY → IDLE after the DW-th step.
  - `if_flush` in BUSY → IDLE immediately, with the result discarded.
- **Bubbles:** an accepted mul/div, no input, or a flushed input loads a bubble into the output registers. A bubble means `out_valid`=0, `reg_wr_addr`=0, result and flags 0.
- **Simultaneous `if_flush` and `in_valid`:** flush wins and the input is dropped.
- **Flush and completion on the same edge:** flush wins and no result is written.
- **Reset:**
  - Every output register goes to 0; `alu_not_zero` is also 0 on reset.
  - FSM goes to IDLE and the iteration counter to 0.
  - Reset mid-operation aborts the operation with no result.

## Timing
- Single-cycle op accepted at edge N: result, flags and address are visible after edge N. Latency is 1; `in_ready` stays 1.
- Mul/div accepted at edge N:
  - `in_ready`=0 from after edge N until after edge N+DW.
  - One radix-2 step occurs per edge N+1 … N+DW.
  - Edge N+DW loads the result with `out_valid`=1 for exactly one cycle. Latency is DW.
- The next instruction can be accepted at edge N+DW+1.
- There is no downstream back-pressure; EX/MEM always accepts.
- Forward source 10 reads the registered `alu_result`, so a bubble forwards 0.

## Structure
- Package `ex_pkg` holds:
  - the `alu_ctrl` op-code constants (AND=0, OR=1, ADD=2, SLL=3, SRL=4, SRA=5, SUB=6, SLT=7, NOR=8, SLTU=9, MULLO=A, MULHIU=B, DIVU=C, REMU=D);
  - the forward-select constants FWD_RF=00, FWD_WB=01, FWD_EX=10;
  - the FSM state encoding.
- Sub-module `md_iter`:
  - DW-step shift-add multiplier and restoring divider, sharing one counter of log2(DW)+1 bits.
  - Handshake: start/op/a/b in, done/result out, abort in.
- The top level holds the muxes, ALU, adder, FSM glue and output registers.

## Test plan
All scenarios use DW=32.
- **Reset:** after reset, all outputs are 0 and `in_ready`=1. Then ADD with A=5, B=7 → `alu_result`=12, `out_valid`=1, `alu_greater`=1 one cycle later.
- **Overflow and zero:**
  - ADD 0x7FFFFFFF + 1 → result 0x80000000, `alu_ovf`=1, `alu_greater`=0.
  - SUB 3 − 3 → `alu_zero`=1, `alu_not_zero`=0.
- **Forwarding:**
  - `forwardA`=10 after a result of 12, plus imm 4 with `alu_src`=1 → 16.
  - `forwardB`=01 with `reg_wr_data_wb`=0xAA → `regB_rd_data_out`=0xAA.
- **Multiply:**
  - MULLO 0xFFFF × 0x10001 → `in_ready` low for 32 cycles, then result 0xFFFFFFFF.
  - MULHIU 0xFFFFFFFF × 2 → 1.
- **Divide:**
  - DIVU 100 / 7 → 14 after 32 cycles; REMU → 2.
  - DIVU 9 / 0 → 0xFFFFFFFF; REMU 9 / 0 → 9.
- **Aborts and bubbles:**
  - `if_flush` at cycle 10 of a DIVU → `in_ready`=1 next cycle, no `out_valid` pulse.
  - `rstb` mid-MULLO → all outputs 0.
  - Branch target: `pc_plus4`=0x100, imm=−1 → 0xFC.
